// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller: FSM state encoding,
// one-hot mode LED codes and pattern memory depth.
package simon_pkg;

    localparam int unsigned MEM_DEPTH = 64;
    localparam int unsigned MODE_W    = 4;

    typedef enum logic [1:0] {
        S_INPUT    = 2'd0,
        S_PLAYBACK = 2'd1,
        S_REPEAT   = 2'd2,
        S_DONE     = 2'd3
    } simon_state_e;

    localparam logic [MODE_W-1:0] MODE_INPUT    = 4'b0001;
    localparam logic [MODE_W-1:0] MODE_PLAYBACK = 4'b0010;
    localparam logic [MODE_W-1:0] MODE_REPEAT   = 4'b0100;
    localparam logic [MODE_W-1:0] MODE_DONE     = 4'b1000;

    // Mode LED pattern shown for each controller state.
    function automatic logic [MODE_W-1:0] mode_of(input simon_state_e s);
        logic [MODE_W-1:0] m;
        case (s)
            S_INPUT:    m = MODE_INPUT;
            S_PLAYBACK: m = MODE_PLAYBACK;
            S_REPEAT:   m = MODE_REPEAT;
            S_DONE:     m = MODE_DONE;
            default:    m = MODE_INPUT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/simon_hold_timer.sv
// Loadable down-counter that stops at zero; load wins over tick.
// Used for playback pacing and for the REPEAT inactivity limit.
module simon_hold_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_tick,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/simon_control.sv
// Simon game control FSM: Mealy pulses to the datapath, playback pacing, mode LEDs.
// Optional REPEAT inactivity timeout enabled by defining SIMON_TIMEOUT_EN.
module simon_control
    import simon_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              dp_legal,
    input  logic              dp_match,
    input  logic              dp_play_last,
    input  logic              dp_full,
    output logic              dp_wr_en,
    output logic              dp_len_inc,
    output logic              dp_idx_clr,
    output logic              dp_idx_inc,
    output logic              dp_show_mem,
    output logic [MODE_W-1:0] mode_leds
);

    localparam int unsigned TMR_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] HOLD_RELOAD = TMR_W'(HOLD_CYCLES - 1);

    simon_state_e r_state;
    simon_state_e w_next_state;
    logic         w_hold_load;
    logic         w_hold_tick;
    logic         w_hold_zero;

    simon_hold_timer #(.W(TMR_W)) u_hold (
        .clk        (clk),
        .rst_n      (rst),
        .i_load     (w_hold_load),
        .i_load_val (HOLD_RELOAD),
        .i_tick     (w_hold_tick),
        .o_zero_c   (w_hold_zero)
    );

`ifdef SIMON_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TO_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic w_to_load;
    logic w_to_tick;
    logic w_to_zero;

    // Counts down from the limit; held at the limit outside REPEAT and on each step.
    simon_hold_timer #(.W(TMR_W)) u_timeout (
        .clk        (clk),
        .rst_n      (rst),
        .i_load     (w_to_load),
        .i_load_val (TO_RELOAD),
        .i_tick     (w_to_tick),
        .o_zero_c   (w_to_zero)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INPUT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and datapath pulses; everything forced quiet while reset is held.
    always_comb begin
        w_next_state = r_state;
        dp_wr_en     = 1'b0;
        dp_len_inc   = 1'b0;
        dp_idx_clr   = 1'b0;
        dp_idx_inc   = 1'b0;
        dp_show_mem  = 1'b0;
        mode_leds    = mode_of(r_state);
        w_hold_load  = 1'b0;
        w_hold_tick  = 1'b0;
`ifdef SIMON_TIMEOUT_EN
        w_to_load    = 1'b1;
        w_to_tick    = 1'b0;
`endif
        if (rst) begin
            unique case (r_state)
                S_INPUT: begin
                    if (step && dp_legal) begin
                        dp_wr_en     = 1'b1;
                        dp_len_inc   = 1'b1;
                        dp_idx_clr   = 1'b1;
                        w_hold_load  = 1'b1;
                        w_next_state = S_PLAYBACK;
                    end
                end
                S_PLAYBACK, S_DONE: begin
                    dp_show_mem = 1'b1;
                    if (w_hold_zero) begin
                        w_hold_load = 1'b1;
                        if (dp_play_last) begin
                            dp_idx_clr = 1'b1;
                            if (r_state == S_PLAYBACK) begin
                                w_next_state = S_REPEAT;
                            end
                        end else begin
                            dp_idx_inc = 1'b1;
                        end
                    end else begin
                        w_hold_tick = 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (step) begin
                        if (!dp_match || (dp_play_last && dp_full)) begin
                            dp_idx_clr   = 1'b1;
                            w_hold_load  = 1'b1;
                            w_next_state = S_DONE;
                        end else if (!dp_play_last) begin
                            dp_idx_inc = 1'b1;
                        end else begin
                            w_next_state = S_INPUT;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (w_to_zero) begin
                        dp_idx_clr   = 1'b1;
                        w_hold_load  = 1'b1;
                        w_next_state = S_DONE;
                    end
                    w_to_load = step;
                    w_to_tick = !step;
`endif
                end
                default: begin
                    w_next_state = S_INPUT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_control.sv
// Self-checking bench for simon_control: game-level expectations per cycle
// derived from hold length, round length and the player's step outcomes.
module tb_simon_control;

    localparam int HOLD = 4;
    localparam int TOUT = 10;

    localparam logic [3:0] M_IN  = 4'b0001;
    localparam logic [3:0] M_PB  = 4'b0010;
    localparam logic [3:0] M_REP = 4'b0100;
    localparam logic [3:0] M_DN  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       step = 1'b0;
    logic       dp_legal = 1'b0;
    logic       dp_match = 1'b0;
    logic       dp_play_last = 1'b0;
    logic       dp_full = 1'b0;
    logic       dp_wr_en, dp_len_inc, dp_idx_clr, dp_idx_inc, dp_show_mem;
    logic [3:0] mode_leds;
    logic [8:0] obs;

    int checks   = 0;
    int failures = 0;

    simon_control #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .step         (step),
        .dp_legal     (dp_legal),
        .dp_match     (dp_match),
        .dp_play_last (dp_play_last),
        .dp_full      (dp_full),
        .dp_wr_en     (dp_wr_en),
        .dp_len_inc   (dp_len_inc),
        .dp_idx_clr   (dp_idx_clr),
        .dp_idx_inc   (dp_idx_inc),
        .dp_show_mem  (dp_show_mem),
        .mode_leds    (mode_leds)
    );

    always #5 clk = ~clk;

    assign obs = {dp_wr_en, dp_len_inc, dp_idx_clr, dp_idx_inc, dp_show_mem, mode_leds};

    // Expected {wr_en,len_inc,idx_clr,idx_inc,show_mem,mode}; wr_en and len_inc always pair up.
    function automatic logic [8:0] expv(input logic wl, input logic clr, input logic inc,
                                        input logic show, input logic [3:0] mode);
        return {wl, wl, clr, inc, show, mode};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reset asserted mid-cycle must take effect at once, even with an accepting step present.
    task automatic test_reset(input string where);
        @(posedge clk);
        #3;
        rst = 1'b0; step = 1'b1; dp_legal = 1'b1; dp_match = rbit(); dp_play_last = rbit(); dp_full = 1'b0;
        #1;
        checks++;
        if (obs !== expv(0, 0, 0, 0, M_IN)) begin
            failures++;
            $display("FAIL reset_%s got=%b exp=%b", where, obs, expv(0, 0, 0, 0, M_IN));
        end
        @(posedge clk);
        #1;
        rst = 1'b1; step = 1'b0; dp_legal = 1'b0;
    endtask

    // Illegal or absent steps are ignored, then one legal step records a pattern.
    task automatic test_input(input int n_idle);
        logic [8:0] e;
        for (int i = 0; i <= n_idle; i++) begin
            @(posedge clk);
            #1;
            dp_match = rbit(); dp_play_last = rbit(); dp_full = 1'b0;
            if (i == n_idle) begin
                step = 1'b1; dp_legal = 1'b1;
                e = expv(1, 1, 0, 0, M_IN);
                e[6] = 1'b1;
            end else begin
                step = rbit(); dp_legal = step ? 1'b0 : rbit();
                e = expv(0, 0, 0, 0, M_IN);
            end
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL input i=%0d step=%b legal=%b got=%b exp=%b", i, step, dp_legal, obs, e);
            end
        end
    endtask

    // Each of len entries is shown HOLD cycles; advance on all but the last, clear after it.
    task automatic test_playback(input int len);
        logic [8:0] e;
        for (int c = 1; c <= len * HOLD; c++) begin
            @(posedge clk);
            #1;
            step = rbit(); dp_legal = rbit(); dp_match = rbit(); dp_full = 1'b0;
            dp_play_last = (((c - 1) / HOLD) == len - 1);
            e = expv(0, (c == len * HOLD), ((c % HOLD) == 0) && (c != len * HOLD), 1, M_PB);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL playback len=%0d cyc=%0d got=%b exp=%b", len, c, obs, e);
            end
        end
    endtask

    // Player repeats the sequence; lose_at<0 means every step matches.
    task automatic test_repeat(input int len, input int lose_at, input logic full);
        logic [8:0] e;
        logic       lose, last;
        for (int i = 0; i < len; i++) begin
            int gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                step = 1'b0; dp_legal = rbit(); dp_match = rbit(); dp_play_last = rbit(); dp_full = rbit();
                @(negedge clk);
                checks++;
                if (obs !== expv(0, 0, 0, 0, M_REP)) begin
                    failures++;
                    $display("FAIL repeat_idle i=%0d got=%b exp=%b", i, obs, expv(0, 0, 0, 0, M_REP));
                end
            end
            lose = (i == lose_at);
            last = (i == len - 1);
            @(posedge clk);
            #1;
            step = 1'b1; dp_legal = rbit(); dp_match = !lose; dp_play_last = last; dp_full = full;
            if (lose || (last && full)) e = expv(0, 1, 0, 0, M_REP);
            else if (!last)             e = expv(0, 0, 1, 0, M_REP);
            else                        e = expv(0, 0, 0, 0, M_REP);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL repeat_step i=%0d len=%0d got=%b exp=%b", i, len, obs, e);
            end
            if (lose || last) break;
        end
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    // DONE loops the stored sequence forever and ignores steps.
    task automatic test_done(input int len, input int cycles);
        logic [8:0] e;
        logic       at, last;
        for (int c = 1; c <= cycles; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            step = rbit(); dp_legal = rbit(); dp_match = rbit(); dp_full = rbit();
            last = ((((c - 1) / HOLD) % len) == len - 1);
            dp_play_last = last;
            at = ((c % HOLD) == 0);
            e = expv(0, at && last, at && !last, 1, M_DN);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL done len=%0d cyc=%0d got=%b exp=%b", len, c, obs, e);
            end
        end
    endtask

`ifdef SIMON_TIMEOUT_EN
    // Inactivity in REPEAT loses after TOUT cycles; a step just before expiry restarts the count.
    task automatic test_timeout(input logic restart);
        logic [8:0] e;
        if (restart) begin
            for (int k = 0; k < TOUT; k++) begin
                @(posedge clk);
                #1;
                step = (k == TOUT - 1); dp_match = 1'b1; dp_play_last = 1'b0; dp_full = 1'b0;
                e = expv(0, 0, (k == TOUT - 1), 0, M_REP);
                @(negedge clk);
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL timeout_restart k=%0d got=%b exp=%b", k, obs, e);
                end
            end
        end
        for (int k = 0; k < TOUT; k++) begin
            @(posedge clk);
            #1;
            step = 1'b0; dp_match = rbit(); dp_play_last = rbit(); dp_full = rbit();
            e = expv(0, (k == TOUT - 1), 0, 0, M_REP);
            @(negedge clk);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL timeout k=%0d got=%b exp=%b", k, obs, e);
            end
        end
        @(posedge clk);
        #1;
    endtask
`else
    // Without the timeout option REPEAT waits indefinitely.
    task automatic test_no_timeout(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            step = 1'b0; dp_match = rbit(); dp_play_last = rbit(); dp_full = rbit();
            @(negedge clk);
            checks++;
            if (obs !== expv(0, 0, 0, 0, M_REP)) begin
                failures++;
                $display("FAIL no_timeout k=%0d got=%b exp=%b", k, obs, expv(0, 0, 0, 0, M_REP));
            end
        end
    endtask
`endif

    initial begin
        test_reset("initial");
        test_input(int'($urandom_range(1, 4)));
        test_reset("mid_playback");

        for (int r = 1; r <= 3; r++) begin
            test_input(int'($urandom_range(0, 4)));
            test_playback(r);
`ifndef SIMON_TIMEOUT_EN
            if (r == 3) test_no_timeout(3 * TOUT);
`endif
            test_repeat(r, -1, 1'b0);
        end
        test_input(int'($urandom_range(0, 2)));
        test_playback(4);
        test_repeat(4, int'($urandom_range(0, 3)), 1'b0);
        test_done(4, 3 * 4 * HOLD);
        test_reset("mid_done");

        test_input(0);
        test_playback(1);
        test_repeat(1, -1, 1'b1);
        test_done(1, 3 * HOLD);
        test_reset("after_win");

        test_input(1);
        test_playback(2);
        test_reset("mid_repeat");

        test_input(0);
        test_playback(2);
        test_repeat(2, -1, 1'b0);

`ifdef SIMON_TIMEOUT_EN
        test_input(0);
        test_playback(1);
        test_timeout(1'b0);
        test_done(1, 2 * HOLD);
        test_reset("after_timeout");
        test_input(0);
        test_playback(2);
        test_timeout(1'b1);
        test_done(2, 2 * 2 * HOLD);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
